// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit with HI/LO registers for the EX stage.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) enabled by `define MULT_DIV_MADD_EN.
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             op_ok;
    logic             accept;
    logic             is_div;
    logic             div_signed;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] quo_u, rem_u;
    logic [WIDTH-1:0] quo, rem;
    logic [2*WIDTH-1:0] ext_a, ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] result;

    always_comb begin
`ifdef MULT_DIV_MADD_EN
        op_ok = 1'b1;
`else
        op_ok = ~op[2];
`endif
        accept = start & ~busy_q & ~req & op_ok;
    end

    // Signed divide runs on magnitudes; the overflow case -2^(W-1)/-1 falls out as quo=a, rem=0.
    always_comb begin
        is_div     = op_q[1] & ~op_q[2];
        div_signed = ~op_q[0];
        neg_a      = div_signed & a_q[WIDTH-1];
        neg_b      = div_signed & b_q[WIDTH-1];
        mag_a      = neg_a ? -a_q : a_q;
        mag_b      = neg_b ? -b_q : b_q;
        quo_u      = mag_a / mag_b;
        rem_u      = mag_a % mag_b;
        quo        = (neg_a ^ neg_b) ? -quo_u : quo_u;
        rem        = neg_a ? -rem_u : rem_u;

        ext_a = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_b = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod  = ext_a * ext_b;

        result = is_div ? {rem, quo} : prod;
`ifdef MULT_DIV_MADD_EN
        if (op_q[2]) begin
            result = op_q[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
        end
`endif
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (accept) begin
            busy_d = 1'b1;
            op_d   = op;
            a_d    = a;
            b_d    = b;
            cnt_d  = (op[1] & ~op[2]) ? DIV_CNT : MULT_CNT;
        end else if (busy_q) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                if (!(is_div && (b_q == '0))) begin
                    {hi_d, lo_d} = result;
                end
            end
        end else if (!req && !start) begin
            if (mthi) hi_d = a;
            if (mtlo) lo_d = a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32, MULT_LAT=5, DIV_LAT=10) against an arithmetic reference model.
// Expectations follow `define MULT_DIV_MADD_EN when it is defined for the build.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    mult_div_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit opAccepted(input logic [2:0] o);
`ifdef MULT_DIV_MADD_EN
        return 1'b1;
`else
        return (o < 3'd4);
`endif
    endfunction

    function automatic int opLatency(input logic [2:0] o);
        return (o == 3'd2 || o == 3'd3) ? 10 : 5;
    endfunction

    // Reference result {hi,lo} for an accepted op, given the HI/LO value at completion.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [63:0] cur);
        longint      sp;
        logic [63:0] up;
        logic [31:0] h;
        logic [31:0] l;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = {32'd0, x} * {32'd0, y};
        h  = cur[63:32];
        l  = cur[31:0];
        case (o)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (y != 0) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        l = x;
                        h = 32'd0;
                    end else begin
                        l = $signed(x) / $signed(y);
                        h = $signed(x) % $signed(y);
                    end
                end
                return {h, l};
            end
            3'd3: begin
                if (y != 0) begin
                    l = x / y;
                    h = x % y;
                end
                return {h, l};
            end
            3'd4: return cur + sp;
            3'd5: return cur + up;
            3'd6: return cur - sp;
            default: return cur - up;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("[TB] %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One op from launch to the first idle cycle; disturb pokes req/start/mtlo while busy.
    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input bit req_start, input bit disturb);
        bit          acc;
        int          lat;
        logic [63:0] prev;
        acc  = !req_start && opAccepted(o);
        lat  = acc ? opLatency(o) : 0;
        prev = {exp_hi, exp_lo};
        if (acc) {exp_hi, exp_lo} = model(o, x, y, prev);

        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        req   = req_start;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s busy c%0d", tag, k), {63'd0, busy}, 64'd1);
            if (k == lat) checkOutput({tag, " hold"}, {hi, lo}, prev);
            if (k == 1) begin
                start = 1'b0;
                req   = 1'b0;
                a     = $urandom;
                b     = $urandom;
            end
            if (disturb && k == 2) begin
                req   = 1'b1;
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
            end
            if (disturb && k == 3) begin
                req   = 1'b0;
                start = 1'b0;
                mtlo  = 1'b1;
            end
            if (disturb && k == 4) mtlo = 1'b0;
        end
        @(negedge clk);
        checkOutput({tag, " idle"}, {63'd0, busy}, 64'd0);
        checkOutput({tag, " result"}, {hi, lo}, {exp_hi, exp_lo});
        start = 1'b0;
        req   = 1'b0;
    endtask

    task automatic writeHiLo(input string tag, input bit wh, input bit wl, input logic [31:0] x, input bit rq);
        @(negedge clk);
        mthi = wh;
        mtlo = wl;
        a    = x;
        req  = rq;
        if (!rq) begin
            if (wh) exp_hi = x;
            if (wl) exp_lo = x;
        end
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        req  = 1'b0;
        checkOutput(tag, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic [2:0]  ro;
        int          sel;

        reset = 1'b1;
        req   = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        applyStimulus("mult -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        checkOutput("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus("divu 100/7", 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        checkOutput("divu const", {hi, lo}, {32'd2, 32'd14});
        applyStimulus("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checkOutput("div const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        applyStimulus("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("div ovf const", {hi, lo}, {32'd0, 32'h8000_0000});
        applyStimulus("div by 0", 3'd2, 32'd5, 32'd0, 1'b0, 1'b0);
        checkOutput("div0 const", {hi, lo}, {32'd0, 32'h8000_0000});

        applyStimulus("mult req", 3'd0, 32'd9, 32'd9, 1'b1, 1'b0);
        applyStimulus("multu disturbed", 3'd1, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1);
        applyStimulus("divu disturbed", 3'd3, 32'd1000, 32'd33, 1'b0, 1'b1);

        writeHiLo("mthi", 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        writeHiLo("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        writeHiLo("mtlo req", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);

        writeHiLo("madd prep hi", 1'b1, 1'b0, 32'd0, 1'b0);
        writeHiLo("madd prep lo", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("maddu 1*1", 3'd5, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MULT_DIV_MADD_EN
        checkOutput("maddu const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        checkOutput("maddu const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 24; i++) begin
            rx  = $urandom;
            ry  = $urandom;
            ro  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            if (sel == 0) ry = 32'd0;
            if (sel == 1) begin
                rx = 32'h8000_0000;
                ry = 32'hFFFF_FFFF;
            end
            if (sel == 2) ry = {28'd0, ry[3:0]};
            applyStimulus($sformatf("rnd%0d op%0d", i, ro), ro, rx, ry, 1'b0, (sel == 3));
        end

        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd77;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset busy", {63'd0, busy}, 64'd0);
        checkOutput("async reset hilo", {hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        writeHiLo("mtlo after reset", 1'b0, 1'b1, 32'd55, 1'b0);
        repeat (12) @(negedge clk);
        checkOutput("discarded div", {hi, lo}, {32'd0, 32'd55});
        checkOutput("discarded busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
